// File: rtl/cpu_mem_pkg.sv
// Shared types and helpers for the CPU memory subsystem.
// Parity storage is built only when MEM_PARITY_EN is defined.
package cpu_mem_pkg;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_ADDR_W = 16;
   localparam int BYTES      = DEF_DATA_W / 8;

   typedef struct packed {
      logic [DEF_DATA_W-1:0] rdata;
      logic                  err;
   } resp_t;

   function automatic logic par8(input logic [7:0] b);
      return ^b;
   endfunction

endpackage

// File: rtl/resp_fifo.sv
// Synchronous response FIFO with full/empty flags.
// A push on a full FIFO is taken only when a pop frees a slot.
module resp_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 17
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wp_q, wp_d;
   logic [AW:0]      rp_q, rp_d;
   logic [WIDTH-1:0] buf_q [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign empty   = (wp_q == rp_q);
   assign full    = (wp_q[AW] != rp_q[AW]) &&
                    (wp_q[AW-1:0] == rp_q[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = buf_q[rp_q[AW-1:0]];

   always_comb begin
      wp_d = wp_q;
      rp_d = rp_q;
      if (do_push) wp_d = wp_q + 1'b1;
      if (do_pop)  rp_d = rp_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wp_q <= '0;
         rp_q <= '0;
      end else begin
         wp_q <= wp_d;
         rp_q <= rp_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) buf_q[wp_q[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/pipelined_memory.sv
// Single-port RAM with byte strobes, read pipeline and credit-guarded FIFO.
// Optional per-byte even parity when MEM_PARITY_EN is defined.
module pipelined_memory
   import cpu_mem_pkg::*;
#(
   parameter int DATA_W       = DEF_DATA_W,
   parameter int ADDR_W       = DEF_ADDR_W,
   parameter int READ_LATENCY = 1,
   parameter int RESP_DEPTH   = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic [DATA_W/8-1:0] req_be,
   output logic                resp_valid,
   input  logic                resp_ready,
   output logic [DATA_W-1:0]   resp_rdata,
   output logic                resp_err
);

   localparam int LANES = DATA_W / 8;
   localparam int CW    = $clog2(RESP_DEPTH + 1);
   localparam int EW    = DATA_W + 1;

   logic [DATA_W-1:0] mem_q [2**ADDR_W];
   logic [CW-1:0]     credit_q, credit_d;
   logic              acc, wr_acc, rd_acc;
   logic              rd_err;
   logic [EW-1:0]     s0_e;
   logic              push_v;
   logic [EW-1:0]     push_e;
   logic [EW-1:0]     fifo_rd;
   logic              fifo_full, fifo_empty;
   logic              pop;

   assign req_ready = !rst && (credit_q < CW'(RESP_DEPTH));
   assign acc       = req_valid && req_ready;
   assign wr_acc    = acc && req_we;
   assign rd_acc    = acc && !req_we;

   always_ff @(posedge clk) begin
      if (wr_acc) begin
         for (int i = 0; i < LANES; i++) begin
            if (req_be[i])
               mem_q[req_addr][i*8 +: 8] <= req_wdata[i*8 +: 8];
         end
      end
   end

`ifdef MEM_PARITY_EN
   logic [LANES-1:0] par_q [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (wr_acc) begin
         for (int i = 0; i < LANES; i++) begin
            if (req_be[i])
               par_q[req_addr][i] <= par8(req_wdata[i*8 +: 8]);
         end
      end
   end

   always_comb begin
      rd_err = 1'b0;
      for (int i = 0; i < LANES; i++) begin
         if (par_q[req_addr][i] != par8(mem_q[req_addr][i*8 +: 8]))
            rd_err = 1'b1;
      end
   end
`else
   assign rd_err = 1'b0;
`endif

   assign s0_e = {mem_q[req_addr], rd_err};

   // Stage 0 is the array read itself; later stages are flops.
   if (READ_LATENCY == 1) begin : g_l1
      assign push_v = rd_acc;
      assign push_e = s0_e;
   end else begin : g_ln
      logic [READ_LATENCY-2:0] pv_q;
      logic [EW-1:0]           pe_q [READ_LATENCY-1];

      always_ff @(posedge clk) begin
         if (rst) begin
            pv_q <= '0;
         end else begin
            pv_q[0] <= rd_acc;
            for (int k = 1; k < READ_LATENCY - 1; k++)
               pv_q[k] <= pv_q[k-1];
         end
      end

      always_ff @(posedge clk) begin
         pe_q[0] <= s0_e;
         for (int k = 1; k < READ_LATENCY - 1; k++)
            pe_q[k] <= pe_q[k-1];
      end

      assign push_v = pv_q[READ_LATENCY-2];
      assign push_e = pe_q[READ_LATENCY-2];
   end

   resp_fifo #(
      .DEPTH (RESP_DEPTH),
      .WIDTH (EW)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_v),
      .wdata (push_e),
      .pop   (pop),
      .rdata (fifo_rd),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign resp_valid = !fifo_empty && !rst;
   assign pop        = resp_valid && resp_ready;
   assign resp_rdata = fifo_rd[EW-1:1];
   assign resp_err   = fifo_rd[0];

   always_comb begin
      credit_d = credit_q;
      unique case ({rd_acc, pop})
         2'b10:   credit_d = credit_q + 1'b1;
         2'b01:   credit_d = credit_q - 1'b1;
         default: credit_d = credit_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) credit_q <= '0;
      else     credit_q <= credit_d;
   end

   // Credit makes an unmatched push into a full FIFO unreachable.
   always_ff @(posedge clk) begin
      if (!rst) assert (!(fifo_full && push_v && !pop));
   end

endmodule

// File: tb/tb_pipelined_memory.sv
// Randomized scoreboard bench for pipelined_memory (L=3, depth 4).
// Define MEM_PARITY_EN to exercise the parity error path.
module tb_pipelined_memory;

   localparam int DW = 16;
   localparam int AW = 16;
   localparam int L  = 3;
   localparam int D  = 4;
   localparam int NP = 24;

   typedef struct {
      logic [DW-1:0] d;
      logic          e;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid, req_ready, req_we;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic [1:0]    req_be;
   logic          resp_valid, resp_ready, resp_err;
   logic [DW-1:0] resp_rdata;

   int            vectors = 0;
   int            miscompares = 0;
   int            cyc = 0;
   exp_t          sb[$];
   logic [DW-1:0] mm [int];
   logic [1:0]    bad [int];
   int            pool [NP];
   bit            rr_rand = 0;
   bit            lat_arm = 0, lat_wait = 0;
   int            lat_t0 = 0;
   bit            held = 0;
   logic [DW-1:0] hd;
   logic          he;

   pipelined_memory #(
      .DATA_W       (DW),
      .ADDR_W       (AW),
      .READ_LATENCY (L),
      .RESP_DEPTH   (D)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_be     (req_be),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk(input bit ok, input string nm,
                      input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL %s: got %h, required %h (cycle %0d)",
                  nm, act, req, cyc);
      end
   endtask

   // Monitor: reference model update and response checking.
   initial begin
      exp_t e;
      int   a;
      forever begin
         @(negedge clk);
         if (rst) begin
            chk(req_ready == 1'b0, "rst_req_ready", 32'(req_ready), 0);
            chk(resp_valid == 1'b0, "rst_resp_valid", 32'(resp_valid), 0);
            sb.delete();
            held = 0;
            lat_wait = 0;
         end else begin
            chk(req_ready == (sb.size() < D), "req_ready",
                32'(req_ready), 32'(sb.size() < D));
            if (held)
               chk(resp_valid && resp_rdata === hd && resp_err === he,
                   "hold", {15'd0, resp_valid, resp_rdata},
                   {15'd0, 1'b1, hd});
            if (lat_wait && resp_valid) begin
               chk(cyc - lat_t0 == L, "latency", 32'(cyc - lat_t0), L);
               lat_wait = 0;
            end
            if (resp_valid && resp_ready) begin
               if (sb.size() == 0) begin
                  chk(0, "spurious_resp", 32'(resp_rdata), 0);
               end else begin
                  e = sb.pop_front();
                  chk(resp_rdata === e.d && resp_err === e.e, "rdata",
                      {15'd0, resp_err, resp_rdata}, {15'd0, e.e, e.d});
               end
            end
            held = resp_valid && !resp_ready;
            hd = resp_rdata;
            he = resp_err;
            if (req_valid && req_ready) begin
               a = int'(req_addr);
               if (req_we) begin
                  if (!mm.exists(a)) mm[a] = '0;
                  for (int i = 0; i < 2; i++)
                     if (req_be[i]) mm[a][i*8 +: 8] = req_wdata[i*8 +: 8];
                  if (bad.exists(a)) bad[a] = bad[a] & ~req_be;
               end else begin
                  e.d = mm.exists(a) ? mm[a] : 'x;
                  e.e = bad.exists(a) && (bad[a] != 0);
                  sb.push_back(e);
                  if (lat_arm) begin
                     lat_t0 = cyc;
                     lat_arm = 0;
                     lat_wait = 1;
                  end
               end
            end
         end
      end
   end

   task automatic rnd_rr();
      if (rr_rand) resp_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic req(input logic we, input logic [AW-1:0] addr,
                      input logic [DW-1:0] wd, input logic [1:0] be);
      bit got = 0;
      @(posedge clk);
      #1;
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wd;
      req_be    = be;
      rnd_rr();
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (req_ready) begin
            got = 1;
            break;
         end
         @(posedge clk);
         #1;
         rnd_rr();
      end
      if (!got) chk(0, "req_timeout", 32'(addr), 0);
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      rnd_rr();
   endtask

   task automatic drain();
      bit done = 0;
      idle();
      rr_rand = 0;
      resp_ready = 1'b1;
      for (int k = 0; k < 500; k++) begin
         @(negedge clk);
         if (sb.size() == 0 && !resp_valid) begin
            done = 1;
            break;
         end
      end
      if (!done) chk(0, "drain_timeout", 32'(sb.size()), 0);
   endtask

   initial begin
      int n;
      int a;
      int r;
      logic [DW-1:0] d;
      rst = 1'b1;
      req_valid = 1'b0;
      req_we = 1'b0;
      req_addr = '0;
      req_wdata = '0;
      req_be = '0;
      resp_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      req(1'b1, 16'h0010, 16'hABCD, 2'b11);
      req(1'b1, 16'h0010, 16'h0012, 2'b01);
      req(1'b0, 16'h0010, '0, '0);
      drain();

      pool[0] = 16'h0010;
      pool[1] = 16'h0020;
      pool[2] = 16'h0030;
      pool[3] = 16'h0000;
      pool[4] = 16'hFFFF;
      for (int i = 5; i < NP; i++) pool[i] = $urandom_range(0, 65535);
      for (int i = 1; i < NP; i++) req(1'b1, 16'(pool[i]), 16'($urandom), 2'b11);
      drain();

      lat_arm = 1;
      req(1'b0, 16'h0020, '0, '0);
      drain();
      chk(lat_wait == 0 && lat_arm == 0, "latency_seen",
          {30'd0, lat_arm, lat_wait}, 0);

      resp_ready = 1'b0;
      n = 0;
      @(posedge clk);
      #1;
      req_valid = 1'b1;
      req_we = 1'b0;
      req_addr = 16'(pool[0]);
      repeat (12) begin
         @(negedge clk);
         if (req_ready) n++;
         @(posedge clk);
         #1 req_addr = 16'(pool[n]);
      end
      chk(n == D, "bp_accepts", 32'(n), D);
      chk(req_ready == 1'b0, "bp_req_ready", 32'(req_ready), 0);
      resp_ready = 1'b1;
      req(1'b0, 16'(pool[4]), '0, '0);
      req(1'b0, 16'(pool[5]), '0, '0);
      drain();

      for (int i = 0; i < 20; i++) req(1'b0, 16'(pool[i]), '0, '0);
      drain();

      resp_ready = 1'b0;
      for (int i = 0; i < 4; i++) req(1'b0, 16'(pool[i]), '0, '0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      req_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      resp_ready = 1'b1;
      repeat (10) @(posedge clk);
      @(negedge clk);
      chk(resp_valid == 1'b0, "post_rst_idle", 32'(resp_valid), 0);

      rr_rand = 1;
      for (int i = 0; i < 400; i++) begin
         a = pool[$urandom_range(0, NP - 1)];
         r = $urandom_range(0, 9);
         if (r < 3) begin
            req(1'b1, 16'(a), 16'($urandom), 2'($urandom_range(0, 3)));
         end else if (r < 5) begin
            d = 16'($urandom);
            req(1'b1, 16'(a), d, 2'b11);
            req(1'b0, 16'(a), '0, '0);
         end else begin
            req(1'b0, 16'(a), '0, '0);
         end
         if ($urandom_range(0, 7) == 0) idle();
         rr_rand = 1;
      end
      drain();

`ifdef MEM_PARITY_EN
      req(1'b1, 16'h0030, 16'h00FF, 2'b11);
      drain();
      dut.par_q[16'h0030][0] = ~dut.par_q[16'h0030][0];
      bad[32'h30] = 2'b01;
      req(1'b0, 16'h0030, '0, '0);
      req(1'b0, 16'h0010, '0, '0);
      drain();
`endif

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
   end

endmodule
